// File: rtl/vcmd_v2_pkg.sv
// Shared opcodes, FSM encoding and payload-length helper for the video command decoder.
// VCMD_V2_SETADDR_EN enables the SET_ADDR opcode and its ADDR state.
package vcmd_v2_pkg;

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_SETADDR = 2'b10;
  localparam logic [1:0] OP_ADDRCLR = 2'b11;

  localparam int BYTES_PER_PIXEL = 3;

  typedef enum logic [1:0] {
    CMD  = 2'd0,
    DATA = 2'd1
`ifdef VCMD_V2_SETADDR_EN
    , ADDR = 2'd2
`endif
  } vcmdState_e;

  // Payload byte count for a WRITE; an argument of 0 means 64 pixels.
  function automatic logic [7:0] writeLen(input logic [5:0] n);
    logic [7:0] pix;
    pix = (n == 6'd0) ? 8'd64 : {2'b00, n};
    return 8'(pix * BYTES_PER_PIXEL);
  endfunction

endpackage

// File: rtl/vcmd_v2_if.sv
// Framebuffer write port: single-cycle strobe with registered address and data.
interface vcmd_v2_if #(
  parameter int AWIDTH = 18,
  parameter int DWIDTH = 8
);
  logic              DataClkOut;
  logic [AWIDTH-1:0] AddrOut;
  logic [DWIDTH-1:0] DataOut;

  modport master (output DataClkOut, AddrOut, DataOut);
  modport slave  (input  DataClkOut, AddrOut, DataOut);
endinterface

// File: rtl/vcmd_byte_sync.sv
// Brings the asynchronous SPI byte strobe into the Clk domain and captures the byte.
module vcmd_byte_sync #(
  parameter int DWIDTH = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ByteClkIn,
  input  logic [DWIDTH-1:0] ByteIn,
  output logic              ByteEvent,
  output logic [DWIDTH-1:0] ByteOut
);

  // sync[1:0] is the two-flop synchronizer, sync[2] holds the prior level for edge detect
  logic [2:0] sync;
  logic       rise;

  assign rise = sync[1] & ~sync[2];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync      <= '0;
      ByteEvent <= 1'b0;
      ByteOut   <= '0;
    end else begin
      sync      <= {sync[1:0], ByteClkIn};
      ByteEvent <= rise;
      if (rise) ByteOut <= ByteIn;
    end
  end

endmodule

// File: rtl/vcmd_v2.sv
// Video command decoder: parses SPI command/payload bytes into framebuffer writes.
// VCMD_V2_SETADDR_EN enables SET_ADDR (opcode 10); otherwise opcode 10 is a NOP.
//
//   state | meaning
//   CMD   | next byte is a command
//   DATA  | consuming WRITE payload, remaining bytes left
//   ADDR  | assembling 3 SET_ADDR bytes, MSB first
module vcmd_v2
  import vcmd_v2_pkg::*;
#(
  parameter int AWIDTH = 18,
  parameter int DWIDTH = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ByteClkIn,
  input  logic [DWIDTH-1:0] ByteIn,
  input  logic              DataModeEnable,
  vcmd_v2_if.master         fb
);

  logic              byteEvent;
  logic [DWIDTH-1:0] byteVal;

  vcmd_byte_sync #(.DWIDTH(DWIDTH)) uSync (
    .Clk       (Clk),
    .Reset     (Reset),
    .ByteClkIn (ByteClkIn),
    .ByteIn    (ByteIn),
    .ByteEvent (byteEvent),
    .ByteOut   (byteVal)
  );

  vcmdState_e        state, stateNext;
  logic [AWIDTH-1:0] addr, addrNext;
  logic [7:0]        remaining, remainingNext;
  logic              strobe, strobeNext;
  logic [AWIDTH-1:0] addrOutReg, addrOutNext;
  logic [DWIDTH-1:0] dataOutReg, dataOutNext;
`ifdef VCMD_V2_SETADDR_EN
  logic [23:0]       asmReg, asmNext;
  logic [1:0]        idx, idxNext;
`endif

  always_comb begin
    stateNext     = state;
    addrNext      = addr;
    remainingNext = remaining;
    strobeNext    = 1'b0;
    addrOutNext   = addrOutReg;
    dataOutNext   = dataOutReg;
`ifdef VCMD_V2_SETADDR_EN
    asmNext       = asmReg;
    idxNext       = idx;
`endif
    if (byteEvent) begin
      case (state)
        CMD: begin
          case (byteVal[7:6])
            OP_WRITE: begin
              remainingNext = writeLen(byteVal[5:0]);
              stateNext     = DATA;
            end
`ifdef VCMD_V2_SETADDR_EN
            OP_SETADDR: begin
              idxNext   = 2'd0;
              stateNext = ADDR;
            end
`endif
            OP_ADDRCLR: addrNext = '0;
            default: ;
          endcase
        end
        DATA: begin
          remainingNext = remaining - 8'd1;
          if (remaining == 8'd1) stateNext = CMD;
          if (DataModeEnable) begin
            strobeNext  = 1'b1;
            addrOutNext = addr;
            dataOutNext = byteVal;
            addrNext    = addr + AWIDTH'(1);
          end
        end
`ifdef VCMD_V2_SETADDR_EN
        ADDR: begin
          asmNext = 24'({asmReg, byteVal});
          idxNext = idx + 2'd1;
          if (idx == 2'd2) begin
            addrNext  = AWIDTH'(asmNext);
            stateNext = CMD;
          end
        end
`endif
        default: stateNext = CMD;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= CMD;
      addr       <= '0;
      remaining  <= '0;
      strobe     <= 1'b0;
      addrOutReg <= '0;
      dataOutReg <= '0;
`ifdef VCMD_V2_SETADDR_EN
      asmReg     <= '0;
      idx        <= '0;
`endif
    end else begin
      state      <= stateNext;
      addr       <= addrNext;
      remaining  <= remainingNext;
      strobe     <= strobeNext;
      addrOutReg <= addrOutNext;
      dataOutReg <= dataOutNext;
`ifdef VCMD_V2_SETADDR_EN
      asmReg     <= asmNext;
      idx        <= idxNext;
`endif
    end
  end

  assign fb.DataClkOut = strobe;
  assign fb.AddrOut    = addrOutReg;
  assign fb.DataOut    = dataOutReg;

endmodule

// File: tb/tb_vcmd_v2.sv
// Scoreboard bench for vcmd_v2: directed byte streams, expected writes queued at issue.
module tb_vcmd_v2;

  logic       Clk;
  logic       Reset;
  logic       ByteClkIn;
  logic [7:0] ByteIn;
  logic       DataModeEnable;

  vcmd_v2_if #(.AWIDTH(18), .DWIDTH(8)) fb ();

  vcmd_v2 #(.AWIDTH(18), .DWIDTH(8)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .ByteClkIn      (ByteClkIn),
    .ByteIn         (ByteIn),
    .DataModeEnable (DataModeEnable),
    .fb             (fb)
  );

  typedef struct {
    logic [17:0] a;
    logic [7:0]  d;
    int          rise;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (!Reset && fb.DataClkOut) begin
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_strobe: actual addr=%h data=%h, required no strobe", fb.AddrOut, fb.DataOut);
      end else begin
        e = q.pop_front();
        if (fb.AddrOut !== e.a || fb.DataOut !== e.d) begin
          mismatched++;
          $display("FAIL strobe: actual addr=%h data=%h, required addr=%h data=%h", fb.AddrOut, fb.DataOut, e.a, e.d);
        end
        compared++;
        if (cyc - e.rise != 4) begin
          mismatched++;
          $display("FAIL latency: actual %0d cycles, required 4", cyc - e.rise);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: actual %h, required %h", name, act, req);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input logic en, input logic expStrobe, input logic [17:0] ea);
    exp_t x;
    @(negedge Clk);
    ByteIn         = b;
    DataModeEnable = en;
    ByteClkIn      = 1'b1;
    if (expStrobe) begin
      x.a = ea; x.d = b; x.rise = cyc;
      q.push_back(x);
    end
    repeat (3) @(negedge Clk);
    ByteClkIn = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic doReset();
    @(negedge Clk);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("reset_strobe", {31'd0, fb.DataClkOut}, 32'd0);
    check("reset_addr",   {14'd0, fb.AddrOut},    32'd0);
    check("reset_data",   {24'd0, fb.DataOut},    32'd0);
    Reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [17:0] base;
    Reset = 1'b1; ByteClkIn = 1'b0; ByteIn = 8'h00; DataModeEnable = 1'b1;
    doReset();

    // basic write, addresses from 0
    sendByte(8'h41, 1, 0, 18'h0);
    sendByte(8'hC0, 1, 1, 18'h0);
    sendByte(8'hC0, 1, 1, 18'h1);
    sendByte(8'hC0, 1, 1, 18'h2);
    // auto-increment across commands
    sendByte(8'h41, 1, 0, 18'h0);
    sendByte(8'h03, 1, 1, 18'h3);
    sendByte(8'h03, 1, 1, 18'h4);
    sendByte(8'h03, 1, 1, 18'h5);

    // SET_ADDR to the top, then wrap; without the feature 0xFF acts as ADDR_CLR
    sendByte(8'h80, 1, 0, 18'h0);
    sendByte(8'h03, 1, 0, 18'h0);
    sendByte(8'hFF, 1, 0, 18'h0);
    sendByte(8'hFF, 1, 0, 18'h0);
    sendByte(8'h41, 1, 0, 18'h0);
`ifdef VCMD_V2_SETADDR_EN
    sendByte(8'h11, 1, 1, 18'h3FFFF);
    sendByte(8'h22, 1, 1, 18'h00000);
    sendByte(8'h33, 1, 1, 18'h00001);
    check("addr_hold", {14'd0, fb.AddrOut}, 32'h1);
    base = 18'h2;
`else
    sendByte(8'h11, 1, 1, 18'h0);
    sendByte(8'h22, 1, 1, 18'h1);
    sendByte(8'h33, 1, 1, 18'h2);
    check("addr_hold", {14'd0, fb.AddrOut}, 32'h2);
    base = 18'h3;
`endif

    // disabled write: consumed, no strobe, no advance
    sendByte(8'h41, 0, 0, 18'h0);
    sendByte(8'h01, 0, 0, 18'h0);
    sendByte(8'h02, 0, 0, 18'h0);
    sendByte(8'h03, 0, 0, 18'h0);
    check("addr_hold_disabled", {14'd0, fb.AddrOut}, {14'd0, base - 18'd1});
    sendByte(8'h41, 1, 0, 18'h0);
    sendByte(8'h44, 1, 1, base);
    sendByte(8'h55, 1, 1, base + 18'd1);
    sendByte(8'h66, 1, 1, base + 18'd2);

    // reset mid-write abandons it
    sendByte(8'h41, 1, 0, 18'h0);
    sendByte(8'h77, 1, 1, base + 18'd3);
    doReset();
    sendByte(8'hC0, 1, 0, 18'h0);
    sendByte(8'h41, 1, 0, 18'h0);
    sendByte(8'hAA, 1, 1, 18'h0);
    sendByte(8'hBB, 1, 1, 18'h1);
    sendByte(8'hCC, 1, 1, 18'h2);

    // N=0 means 64 pixels = 192 bytes; the next byte is a command
    sendByte(8'h40, 1, 0, 18'h0);
    for (int i = 0; i < 192; i++) sendByte(8'(i + 1), 1, 1, 18'(3 + i));
    sendByte(8'hC0, 1, 0, 18'h0);
    sendByte(8'h00, 1, 0, 18'h0);
    sendByte(8'h41, 1, 0, 18'h0);
    sendByte(8'hD1, 1, 1, 18'h0);
    sendByte(8'hD2, 1, 1, 18'h1);
    sendByte(8'hD3, 1, 1, 18'h2);

    repeat (10) @(negedge Clk);
    check("pending_expected", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vcmd_v2.md
# vcmd_v2

Video command decoder. Sits between the SPI slave byte receiver and the frame-buffer write port. It parses a byte stream of commands and payload and emits addressed data-byte write strobes. Framebuffer addresses auto-increment across commands, so consecutive write commands fill consecutive locations.

## Interface
- AWIDTH, default 18: framebuffer address width.
- DWIDTH, default 8: data byte width; must equal the SPI byte width.
- Clk  in  1: system clock; everything is registered on the rising edge.
- Reset  in  1: synchronous, active-high reset.
- ByteClkIn  in  1: byte-received strobe from the SPI receiver. It is asynchronous to Clk and goes high when a byte completes.
- ByteIn  in  DWIDTH: received byte; stable while ByteClkIn is high and until the next byte.
- DataModeEnable  in  1: when 0, write payload is consumed but not emitted.
- DataClkOut  out  1: single-cycle write strobe.
- AddrOut  out  AWIDTH: write address, valid with DataClkOut.
- DataOut  out  DWIDTH: write data, valid with DataClkOut.

## Operation
- Command byte format: bits [7:6] are the opcode, bits [5:0] are the argument N.
  - 00 NOP: no effect.
  - 01 WRITE: followed by 3·P payload bytes, where P = N and N=0 means 64. There are three bytes per pixel.
  - 10 SET_ADDR: followed by 3 address bytes, MSB first. The low AWIDTH bits of the 24-bit value load the address register.
  - 11 ADDR_CLR: address register := 0.
- FSM states:
  - CMD: next byte is decoded as a command. WRITE goes to DATA with remaining := 3·P (8-bit counter, max 192). SET_ADDR goes to ADDR with index 0. NOP and ADDR_CLR stay in CMD.
  - DATA: each byte decrements remaining and returns to CMD at 0. If DataModeEnable=1, each byte pulses DataClkOut with DataOut=byte and AddrOut=current address, then the address increments. If DataModeEnable=0, there is no pulse and no increment.
  - ADDR: shifts the byte into a 24-bit assembly register. After the third byte it loads the address and returns to CMD.
- Address arithmetic is modulo 2^AWIDTH: 2^AWIDTH−1 wraps to 0.
- DataModeEnable is sampled at each byte event.
- Reset:
  - FSM = CMD, address = 0, remaining = 0, synchronizer cleared.
  - DataClkOut=0, AddrOut=0, DataOut=0.
  - A reset mid-command abandons the command, and the next byte is treated as a command.

## Timing
- ByteClkIn passes through a 2-flop synchronizer plus a rising-edge detector. A byte event fires on the third Clk edge after ByteClkIn rises. ByteIn is captured in that same cycle.
- DataClkOut goes high the cycle after the byte event, is high for exactly 1 cycle, and AddrOut/DataOut are registered with it. Latency from ByteClkIn rise to DataClkOut high is 4 Clk cycles.
- AddrOut holds the last written address between strobes. The internal increment is not visible until the next strobe.
- Byte spacing must be at least 4 Clk cycles, and ByteClkIn high time must be at least 2 Clk cycles. Faster input is out of spec.
- Reset asserted in the same cycle as a byte event: reset wins and the byte is dropped.

## Configuration
- VCMD_V2_SETADDR_EN defined: SET_ADDR and the ADDR state are implemented as above.
- Not defined:
  - Opcode 10 is decoded as NOP and consumes no payload.
  - The ADDR state and the 24-bit assembly register are absent.
  - Addresses advance only via writes and ADDR_CLR.

## Structure
- Package vcmd_v2_pkg holds:
  - opcode localparams OP_NOP, OP_WRITE, OP_SETADDR, OP_ADDRCLR;
  - FSM state encoding CMD/DATA/ADDR;
  - BYTES_PER_PIXEL=3.
- One sub-module, vcmd_byte_sync: the ByteClkIn synchronizer plus edge detect. It outputs a one-cycle ByteEvent and the registered byte.

## Test plan
- Reset, then bytes 0x41, 0xC0, 0xC0, 0xC0 with DataModeEnable=1 -> 3 strobes, AddrOut 0,1,2, DataOut 0xC0 each; no strobe for 0x41.
- Then 0x41, 0x03, 0x03, 0x03 -> strobes at AddrOut 3,4,5 with DataOut 0x03.
- SET_ADDR 0x80, 0x03, 0xFF, 0xFF, then 0x41 followed by 0x11, 0x22, 0x33 -> AddrOut 0x3FFFF, 0x00000, 0x00001 (wrap).
- DataModeEnable=0 during 0x41 plus 3 bytes -> no DataClkOut. Following enabled write starts at the unadvanced address.
- Reset after 0x41 and one payload byte, then 0xC0, 0x41, 0xAA, 0xBB, 0xCC -> 0xC0 acts as ADDR_CLR; strobes at 0,1,2.
- 0x40 then 192 payload bytes -> 192 strobes. The 193rd byte is decoded as a command. Latency from ByteClkIn rise to strobe is 4 cycles.
